// File: rtl/riscv_mini_pkg.sv
// Shared constants for the mini pipeline: instruction field positions,
// opcode values, funct3 codes and the ALU operation encoding.
package riscv_mini_pkg;

  // Instruction field LSB positions
  localparam int OPC_LSB = 0;   // [1:0]
  localparam int RD_LSB  = 2;   // [4:2]
  localparam int RS1_LSB = 5;   // [7:5]
  localparam int RS2_LSB = 8;   // [10:8]
  localparam int F2_LSB  = 11;  // [12:11]
  localparam int F3_LSB  = 13;  // [15:13]
  localparam int IMM_LSB = 8;   // simm [12:8], limm {[15:13],[12:8]}

  // Opcodes
  localparam logic [1:0] OPC_R   = 2'b00;
  localparam logic [1:0] OPC_I   = 2'b01;
  localparam logic [1:0] OPC_L   = 2'b10;
  localparam logic [1:0] OPC_OUT = 2'b11;

  // funct3 codes
  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_SUB = 3'b011;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_SR  = 3'b101;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;

  // OUT sub-functions (funct3)
  localparam logic [2:0] OUT_PASS = 3'b000;
  localparam logic [2:0] OUT_CMP  = 3'b011;
  localparam logic [2:0] OUT_AND  = 3'b111;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_SLL = 4'd2,
    ALU_SLT = 4'd3,
    ALU_XOR = 4'd4,
    ALU_SRL = 4'd5,
    ALU_SRA = 4'd6,
    ALU_OR  = 4'd7,
    ALU_AND = 4'd8
  } alu_op_e;

  // Map {alt, funct3} to an ALU operation
  function automatic alu_op_e alu_sel(input logic [2:0] f3, input logic alt);
    alu_op_e op;
    op = ALU_ADD;
    case (f3)
      F3_ADD: op = alt ? ALU_SUB : ALU_ADD;
      F3_SLL: op = ALU_SLL;
      F3_SLT: op = ALU_SLT;
      F3_SUB: op = ALU_SUB;
      F3_XOR: op = ALU_XOR;
      F3_SR:  op = alt ? ALU_SRA : ALU_SRL;
      F3_OR:  op = ALU_OR;
      F3_AND: op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/riscv_mini_pipe_alu.sv
// Combinational ALU for the mini pipeline; all arithmetic wraps at WIDTH bits.
module alu_w
  import riscv_mini_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  localparam int SW = $clog2(WIDTH);

  logic [SW-1:0] shamt;

  assign shamt = b[SW-1:0];

  // Operation select
  always_comb begin
    y = '0;
    case (alu_op_e'(op))
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_SLL: y = a << shamt;
      ALU_SLT: y = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_XOR: y = a ^ b;
      ALU_SRL: y = a >> shamt;
      ALU_SRA: y = $signed(a) >>> shamt;
      ALU_OR:  y = a | b;
      ALU_AND: y = a & b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/riscv_mini_pipe.sv
// Two-stage (ID, EX) mini pipeline with an 8-entry register file and a
// result FIFO. EX retires by writing a register or pushing the FIFO; a full
// FIFO with no consumer freezes the whole pipe.
module riscv_mini_pipe
  import riscv_mini_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [15:0]      instr,
  input  logic             instr_valid,
  output logic             instr_ready,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             busy
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  // ID stage
  logic        id_valid;
  logic [15:0] id_instr;

  // EX stage
  logic             ex_valid;
  logic [1:0]       ex_op;
  logic [2:0]       ex_rd;
  logic [3:0]       ex_alu_op;
  logic [2:0]       ex_f3;
  logic             ex_alt;
  logic [WIDTH-1:0] ex_a;
  logic [WIDTH-1:0] ex_b;

  // Register file and FIFO
  logic [WIDTH-1:0] regs [8];
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic [PW:0]      count;

  // Decode of ID
  logic [1:0]       id_op;
  logic [2:0]       id_rd;
  logic [2:0]       id_rs1;
  logic [2:0]       id_rs2;
  logic             id_alt_raw;
  logic             id_alt;
  logic [2:0]       id_f3;
  logic [7:0]       id_limm8;
  logic [WIDTH-1:0] id_simm;
  logic [WIDTH-1:0] id_limm;
  logic [WIDTH-1:0] rs1_val;
  logic [WIDTH-1:0] rs2_val;
  logic [WIDTH-1:0] id_b;

  logic [WIDTH-1:0] alu_y;
  logic [WIDTH-1:0] ex_wdata;
  logic [WIDTH-1:0] out_val;
  logic             ex_we;
  logic             ex_is_out;
  logic             stall;
  logic             push;
  logic             pop;
  logic             accept;

  assign id_op      = id_instr[OPC_LSB +: 2];
  assign id_rd      = id_instr[RD_LSB  +: 3];
  assign id_rs1     = id_instr[RS1_LSB +: 3];
  assign id_rs2     = id_instr[RS2_LSB +: 3];
  assign id_alt_raw = id_instr[F2_LSB];
  assign id_f3      = id_instr[F3_LSB  +: 3];
  assign id_limm8   = {id_instr[F3_LSB +: 3], id_instr[IMM_LSB +: 5]};
  assign id_simm    = {{(WIDTH-5){id_instr[IMM_LSB+4]}}, id_instr[IMM_LSB +: 5]};
  assign id_limm    = WIDTH'(id_limm8);

  // For I-type the funct2 bit is also the immediate, so an ADDI with a
  // negative immediate must not turn into a subtract.
  assign id_alt = (id_op == OPC_I && id_f3 == F3_ADD) ? 1'b0 : id_alt_raw;

  assign ex_is_out = ex_valid && (ex_op == OPC_OUT);
  assign ex_we     = ex_valid && (ex_op != OPC_OUT);
  assign ex_wdata  = (ex_op == OPC_L) ? ex_b : alu_y;

  // Register read with bypass from the retiring EX write
  always_comb begin
    rs1_val = regs[id_rs1];
    rs2_val = regs[id_rs2];
    if (ex_we && ex_rd == id_rs1) rs1_val = ex_wdata;
    if (ex_we && ex_rd == id_rs2) rs2_val = ex_wdata;
  end

  // Second operand: register for R/OUT, immediate for I/L
  always_comb begin
    id_b = rs2_val;
    case (id_op)
      OPC_I:   id_b = id_simm;
      OPC_L:   id_b = id_limm;
      default: id_b = rs2_val;
    endcase
  end

  alu_w #(.WIDTH(WIDTH)) u_alu (
    .op (ex_alu_op),
    .a  (ex_a),
    .b  (ex_b),
    .y  (alu_y)
  );

  // Value pushed by an OUT instruction
  always_comb begin
    out_val = '0;
    case (ex_f3)
      OUT_PASS: out_val = ex_a;
      OUT_CMP:  out_val = {{(WIDTH-1){1'b0}}, ((ex_a == ex_b) ^ ex_alt)};
      OUT_AND:  out_val = ex_alt ? '0 : (ex_a & ex_b);
      default:  out_val = '0;
    endcase
  end

  assign stall        = ex_is_out && (count == FULL) && !result_ready;
  assign push         = ex_is_out && !stall;
  assign pop          = result_ready && (count != '0);
  assign instr_ready  = rst_n && !stall;
  assign accept       = instr_valid && instr_ready;
  assign result_valid = (count != '0);
  assign result       = result_valid ? mem[rptr] : '0;
  assign busy         = id_valid || ex_valid;

  // Pipeline stage advance; everything holds on stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_valid  <= 1'b0;
      id_instr  <= '0;
      ex_valid  <= 1'b0;
      ex_op     <= '0;
      ex_rd     <= '0;
      ex_alu_op <= '0;
      ex_f3     <= '0;
      ex_alt    <= 1'b0;
      ex_a      <= '0;
      ex_b      <= '0;
    end else if (!stall) begin
      id_valid  <= accept;
      id_instr  <= accept ? instr : '0;
      ex_valid  <= id_valid;
      ex_op     <= id_op;
      ex_rd     <= id_rd;
      ex_alu_op <= alu_sel(id_f3, id_alt);
      ex_f3     <= id_f3;
      ex_alt    <= id_alt;
      ex_a      <= rs1_val;
      ex_b      <= id_b;
    end
  end

  // Register file write on EX retire
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else if (ex_we && !stall) begin
      regs[ex_rd] <= ex_wdata;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FIFO storage; contents are only observable while count is non-zero
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= out_val;
  end

endmodule

// File: tb/tb_riscv_mini_pipe.sv
// Directed bench for riscv_mini_pipe: an 8-bit and a 16-bit instance, expected
// FIFO outputs queued at issue and compared as they are popped.
module tb_riscv_mini_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] instr8, instr16;
  logic        iv8, iv16, ir8, ir16;
  logic        rr8, rr16, rv8, rv16, busy8, busy16;
  logic [7:0]  res8;
  logic [15:0] res16;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [15:0] q8[$];
  logic [15:0] q16[$];

  always #5 clk = ~clk;

  riscv_mini_pipe #(.WIDTH(8), .DEPTH(4)) u8 (
    .clk(clk), .rst_n(rst_n), .instr(instr8), .instr_valid(iv8), .instr_ready(ir8),
    .result(res8), .result_valid(rv8), .result_ready(rr8), .busy(busy8)
  );

  riscv_mini_pipe #(.WIDTH(16), .DEPTH(4)) u16 (
    .clk(clk), .rst_n(rst_n), .instr(instr16), .instr_valid(iv16), .instr_ready(ir16),
    .result(res16), .result_valid(rv16), .result_ready(rr16), .busy(busy16)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] li(input int rd, input logic [7:0] imm);
    return {imm, 3'b000, 3'(rd), 2'b10};
  endfunction

  function automatic logic [15:0] addi(input int rd, input int rs1, input logic [4:0] simm);
    return {3'b000, simm, 3'(rs1), 3'(rd), 2'b01};
  endfunction

  function automatic logic [15:0] rop(input logic [2:0] f3, input logic alt,
                                      input int rd, input int rs1, input int rs2);
    return {f3, 1'b0, alt, 3'(rs2), 3'(rs1), 3'(rd), 2'b00};
  endfunction

  function automatic logic [15:0] outi(input logic [2:0] f3, input logic alt,
                                       input int rs1, input int rs2);
    return {f3, 1'b0, alt, 3'(rs2), 3'(rs1), 3'b000, 2'b11};
  endfunction

  // Issue one instruction starting at a negedge; returns at the negedge after acceptance
  task automatic send(input bit d16, input logic [15:0] w, input bit has_exp,
                      input logic [15:0] exp, output int waits);
    logic rdy;
    waits = 0;
    if (d16) begin instr16 = w; iv16 = 1'b1; end
    else     begin instr8  = w; iv8  = 1'b1; end
    #1;
    rdy = d16 ? ir16 : ir8;
    while (!rdy && waits < 50) begin
      waits++;
      @(negedge clk); #1;
      rdy = d16 ? ir16 : ir8;
    end
    check("accept", {15'd0, rdy}, 16'd1);
    if (has_exp) begin
      if (d16) q16.push_back(exp);
      else     q8.push_back(exp);
    end
    @(negedge clk);
    if (d16) iv16 = 1'b0;
    else     iv8  = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q8.size() != 0 || q16.size() != 0 || rv8 || rv16) && n < 60) begin
      @(negedge clk); #1;
      n++;
    end
    check("drain_q8", 16'(q8.size()), 16'd0);
    check("drain_q16", 16'(q16.size()), 16'd0);
  endtask

  // Scoreboard: compare whatever the consumer pops this cycle
  always @(negedge clk) begin
    logic [15:0] e;
    #2;
    if (rst_n && rv8 && rr8) begin
      if (q8.size() == 0) check("out8_unexpected", 16'(q8.size()), 16'd1);
      else begin
        e = q8.pop_front();
        check("out8", {8'h00, res8}, e);
      end
    end
    if (rst_n && rv16 && rr16) begin
      if (q16.size() == 0) check("out16_unexpected", 16'(q16.size()), 16'd1);
      else begin
        e = q16.pop_front();
        check("out16", res16, e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    rst_n = 1'b0;
    instr8 = '0; instr16 = '0; iv8 = 1'b0; iv16 = 1'b0;
    rr8 = 1'b1; rr16 = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_rv", {15'd0, rv8}, 16'd0);
    check("rst_busy", {15'd0, busy8}, 16'd0);
    check("rst_ready", {15'd0, ir8}, 16'd0);
    check("rst_result", {8'h00, res8}, 16'h0000);
    check("rst_rv16", {15'd0, rv16}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("ready_after_rst", {15'd0, ir8}, 16'd1);
    check("ready16_after_rst", {15'd0, ir16}, 16'd1);

    // Single OUT latency
    @(negedge clk);
    send(0, li(1, 8'h05), 0, 16'h0, w);
    send(0, outi(3'b000, 0, 1, 0), 1, 16'h0005, w);
    @(negedge clk); #1;
    check("lat_edge1_rv", {15'd0, rv8}, 16'd0);
    @(negedge clk); #1;
    check("lat_edge2_rv", {15'd0, rv8}, 16'd1);
    check("lat_edge2_res", {8'h00, res8}, 16'h0005);
    drain();

    // Forwarding, back-to-back dependent
    @(negedge clk);
    send(0, li(1, 8'h03), 0, 16'h0, w);
    send(0, addi(2, 1, 5'h1F), 0, 16'h0, w);
    check("fwd_addi_wait", 16'(w), 16'd0);
    send(0, outi(3'b000, 0, 2, 0), 1, 16'h0002, w);
    check("fwd_out_wait", 16'(w), 16'd0);
    drain();

    // Back-pressure: six OUTs into a 4-entry FIFO with no consumer
    @(negedge clk);
    rr8 = 1'b0;
    send(0, li(1, 8'h05), 0, 16'h0, w);
    for (int i = 0; i < 6; i++) send(0, outi(3'b000, 0, 1, 0), 1, 16'h0005, w);
    repeat (4) @(negedge clk);
    #1;
    check("bp_ready_low", {15'd0, ir8}, 16'd0);
    check("bp_rv", {15'd0, rv8}, 16'd1);
    check("bp_busy", {15'd0, busy8}, 16'd1);
    check("bp_nothing_popped", 16'(q8.size()), 16'd6);
    @(negedge clk);
    rr8 = 1'b1;
    drain();

    // Compares and assorted ALU ops
    @(negedge clk);
    send(0, outi(3'b011, 0, 1, 1), 1, 16'h0001, w);
    send(0, outi(3'b011, 1, 1, 1), 1, 16'h0000, w);
    send(0, li(1, 8'h80), 0, 16'h0, w);
    send(0, li(2, 8'h01), 0, 16'h0, w);
    send(0, rop(3'b010, 0, 3, 1, 2), 0, 16'h0, w);
    send(0, outi(3'b000, 0, 3, 0), 1, 16'h0001, w);
    send(0, li(4, 8'hF0), 0, 16'h0, w);
    send(0, rop(3'b101, 1, 5, 4, 2), 0, 16'h0, w);
    send(0, outi(3'b000, 0, 5, 0), 1, 16'h00F8, w);
    send(0, rop(3'b000, 1, 6, 2, 1), 0, 16'h0, w);
    send(0, outi(3'b000, 0, 6, 0), 1, 16'h0081, w);
    send(0, outi(3'b111, 0, 4, 1), 1, 16'h0080, w);
    send(0, rop(3'b001, 0, 7, 4, 2), 0, 16'h0, w);
    send(0, outi(3'b000, 0, 7, 0), 1, 16'h00E0, w);
    drain();

    // Reset mid-stream: two FIFO entries and EX occupied
    @(negedge clk);
    rr8 = 1'b0;
    for (int i = 0; i < 3; i++) send(0, outi(3'b000, 0, 1, 0), 0, 16'h0, w);
    @(negedge clk);
    #1;
    check("pre_rst_rv", {15'd0, rv8}, 16'd1);
    check("pre_rst_busy", {15'd0, busy8}, 16'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_rv", {15'd0, rv8}, 16'd0);
    check("midrst_busy", {15'd0, busy8}, 16'd0);
    check("midrst_ready", {15'd0, ir8}, 16'd0);
    check("midrst_result", {8'h00, res8}, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    rr8 = 1'b1;
    #1;
    check("ready_after_midrst", {15'd0, ir8}, 16'd1);
    @(negedge clk);
    send(0, outi(3'b000, 0, 1, 0), 1, 16'h0000, w);
    drain();

    // WIDTH=16 sign/zero extension
    @(negedge clk);
    send(1, addi(2, 0, 5'h10), 0, 16'h0, w);
    send(1, outi(3'b000, 0, 2, 0), 1, 16'hFFF0, w);
    send(1, li(3, 8'hFF), 0, 16'h0, w);
    send(1, outi(3'b000, 0, 3, 0), 1, 16'h00FF, w);
    drain();

    @(negedge clk);
    #1;
    check("end_rv8", {15'd0, rv8}, 16'd0);
    check("end_busy16", {15'd0, busy16}, 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/riscv_mini_pipe.md
RISCV_MINI_PIPE -- requirements
Module: riscv_mini_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8: datapath and register width, legal values 8 or more.
REQ-002 SHALL have parameter DEPTH, default 4: result FIFO entries, a power of 2 and at least 2.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port instr, input, 16 bits: instruction word.
REQ-006 SHALL have port instr_valid, input, 1 bit: instr is presented.
REQ-007 SHALL have port instr_ready, output, 1 bit: the block can accept instr this cycle.
REQ-008 SHALL have port result, output, WIDTH bits: head of the result FIFO.
REQ-009 SHALL have port result_valid, output, 1 bit: the FIFO is non-empty.
REQ-010 SHALL have port result_ready, input, 1 bit: the consumer pops the head.
REQ-011 SHALL have port busy, output, 1 bit: any pipeline stage is occupied.

Function
REQ-012 SHALL decode instruction fields as follows:
- opcode = instr[1:0]
- rd = instr[4:2]
- rs1 = instr[7:5]
- rs2 = instr[10:8]
- funct2 = instr[12:11]
- funct3 = instr[15:13]
REQ-013 SHALL treat opcodes as: 00 R (rd = rs1 op rs2); 01 I (rd = rs1 op simm); 10 L (rd = limm); 11 OUT (push to FIFO, no register write).
REQ-014 SHALL form simm as instr[12:8] sign-extended to WIDTH bits, and limm as {instr[15:13], instr[12:8]} zero-extended to WIDTH bits.
REQ-015 SHALL select the ALU op by {funct2[0], funct3}:
- x000 ADD, or SUB when funct2[0]=1
- 001 SLL
- 010 SLT (signed)
- 011 SUB
- 100 XOR
- 101 SRL, or SRA when funct2[0]=1
- 110 OR
- 111 AND
- shift amount = b[clog2(WIDTH)-1:0]
- arithmetic wraps modulo 2^WIDTH
REQ-016 SHALL push these values for OUT:
- funct3=000: rs1 value
- funct3=011, funct2[0]=0: 1 if rs1==rs2, else 0
- funct3=011, funct2[0]=1: the inverse of that result
- funct3=111, funct2[0]=0: rs1 AND rs2
- any other combination: 0
REQ-017 SHALL hold 8 registers of WIDTH bits; all registers are writable, including r0.
REQ-018 SHALL accept an instruction on a rising edge where instr_valid=1 and instr_ready=1, and load it into stage ID.
REQ-019 SHALL, on each non-stalled edge:
- retire stage EX, by writing the register file or pushing the FIFO;
- move ID to EX with operands read from the register file;
- load ID with the new instruction or a bubble.
REQ-020 SHALL bypass the EX write data to the ID operand read when EX writes a register equal to rs1 or rs2 on the same edge; back-to-back dependent instructions need no stall.
REQ-021 SHALL make a result visible at result_valid exactly 2 edges after acceptance when the FIFO is not full.
REQ-022 SHALL define stall = EX holds an OUT instruction, FIFO count == DEPTH, and result_ready == 0; while stall is high, all stages hold and instr_ready is 0.
REQ-023 SHALL, on an edge with a push and a pop while the FIFO is full, complete both and leave the count unchanged.
REQ-024 SHALL return FIFO entries in push order, with read and write pointers wrapping modulo DEPTH.
REQ-025 SHALL ignore instr contents whenever instr_valid=0; a bubble is inserted.

Reset
REQ-026 SHALL, while rst_n is low, immediately force all of the following:
- registers to 0
- pipeline stages empty
- FIFO empty, pointers 0
- result_valid 0, result 0, busy 0, instr_ready 0
REQ-027 SHALL, on reset mid-operation, discard in-flight instructions and FIFO contents; no register write occurs on the reset edge.
REQ-028 SHALL drive instr_ready to 1 in the first cycle after rst_n rises.

Structure
REQ-029 SHALL place the opcode constants, ALU op encodings and field bit positions in shared package riscv_mini_pkg.
REQ-030 SHALL implement the ALU as sub-module alu_w, parametrised by WIDTH; the FIFO and register file are written inline.

Verification (WIDTH=8, DEPTH=4 unless stated)
REQ-031 SHALL cover single OUT latency: reset, then LI r1,5 followed by OUT r1 (funct3=000) -> result_valid rises 2 edges after the OUT is accepted, with result=0x05.
REQ-032 SHALL cover forwarding: back-to-back LI r1,3; ADDI r2,r1,-1; OUT r2 -> result=0x02, with no instr_ready drop.
REQ-033 SHALL cover back-pressure: result_ready=0 and 6 OUT instructions of r1=0x05 -> 4 entries held and instr_ready=0; then result_ready=1 -> six 0x05 values, in order, with no loss or duplication.
REQ-034 SHALL cover compares: OUT eq r1,r1 -> 0x01; OUT ne r1,r1 -> 0x00; r1=0x80, r2=0x01, R-type SLT r3 then OUT r3 -> 0x01.
REQ-035 SHALL cover reset mid-stream: rst_n low with 2 FIFO entries and EX occupied -> result_valid=0 and busy=0 immediately; after release, OUT r1 -> 0x00.
REQ-036 SHALL cover WIDTH=16 sign extension: ADDI r2,r0,-16 then OUT r2 -> 0xFFF0; LI r3,0xFF then OUT r3 -> 0x00FF.
